// File: rtl/ss_display_pkg.sv
// rtl/ss_display_pkg.sv - shared constants and types for the ss_display seven-segment driver
package ss_display_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment bits are {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  typedef logic [1:0] digit_sel_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational nibble to active-low segment decoder (SS_DISPLAY_HEX_EN enables A-F)
module bcd_to_7seg
  import ss_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (nibble)
      4'd0:  segments = SEG_0;
      4'd1:  segments = SEG_1;
      4'd2:  segments = SEG_2;
      4'd3:  segments = SEG_3;
      4'd4:  segments = SEG_4;
      4'd5:  segments = SEG_5;
      4'd6:  segments = SEG_6;
      4'd7:  segments = SEG_7;
      4'd8:  segments = SEG_8;
      4'd9:  segments = SEG_9;
`ifdef SS_DISPLAY_HEX_EN
      4'd10: segments = SEG_A;
      4'd11: segments = SEG_B;
      4'd12: segments = SEG_C;
      4'd13: segments = SEG_D;
      4'd14: segments = SEG_E;
      4'd15: segments = SEG_F;
`else
      // Non-BCD codes stay dark rather than showing garbage
      default: segments = SEG_BLANK;
`endif
    endcase
  end

endmodule

// File: rtl/ss_display.sv
// rtl/ss_display.sv - four-digit multiplexed seven-segment driver (SS_DISPLAY_HEX_EN selects hex decode)
module ss_display
  import ss_display_pkg::*;
#(
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_register,
  output logic [3:0]  control_pins,
  output logic [6:0]  display_pins
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0]      prescale;
  digit_sel_t            digit_sel;
  logic [3:0]            nibble;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] enable_next;

  // Nibble is taken live so input changes show up one cycle later
  assign nibble = bcd_register[4*digit_sel +: 4];

  bcd_to_7seg u_decoder (
    .nibble   (nibble),
    .segments (seg_next)
  );

  always_comb begin
    enable_next            = '1;
    enable_next[digit_sel] = 1'b0;
  end

  // Outputs reflect the current digit_sel, so each digit owns exactly REFRESH_CYCLES edges
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale     <= '0;
      digit_sel    <= '0;
      control_pins <= '1;
      display_pins <= SEG_BLANK;
    end else begin
      control_pins <= enable_next;
      display_pins <= seg_next;
      if (prescale == CNT_LAST) begin
        prescale  <= '0;
        digit_sel <= digit_sel + 1'b1;
      end else begin
        prescale <= prescale + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ss_display.sv
// tb/tb_ss_display.sv - self-checking bench for ss_display (honours SS_DISPLAY_HEX_EN)
module tb_ss_display;

  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd = 16'h0000;
  logic [3:0]  ctrl_a, ctrl_b;
  logic [6:0]  disp_a, disp_b;

  int n_pass  = 0;
  int n_total = 0;
  int edges   = 0;
  logic [6:0] seg_tab [16];

  always #5 clk = ~clk;

  ss_display #(.REFRESH_CYCLES(R)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .bcd_register (bcd),
    .control_pins (ctrl_a),
    .display_pins (disp_a)
  );

  ss_display #(.REFRESH_CYCLES(1)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .bcd_register (bcd),
    .control_pins (ctrl_b),
    .display_pins (disp_b)
  );

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Reference: edge k after reset release shows digit floor((k-1)/R) mod 4
  task automatic step(input logic r, input logic [15:0] v);
    int da, db;
    logic [3:0] ec_a, ec_b;
    logic [6:0] ed_a, ed_b;
    rst = r;
    bcd = v;
    @(posedge clk);
    if (r) begin
      edges = 0;
      ec_a = 4'b1111; ec_b = 4'b1111;
      ed_a = 7'h7F;   ed_b = 7'h7F;
    end else begin
      edges++;
      da = ((edges - 1) / R) % 4;
      db = (edges - 1) % 4;
      ec_a = 4'b1111 ^ (4'b0001 << da);
      ec_b = 4'b1111 ^ (4'b0001 << db);
      ed_a = seg_tab[(v >> (4 * da)) & 16'hF];
      ed_b = seg_tab[(v >> (4 * db)) & 16'hF];
    end
    @(negedge clk);
    check("ctrl_r4", {3'b000, ctrl_a}, {3'b000, ec_a});
    check("disp_r4", disp_a, ed_a);
    check("ctrl_r1", {3'b000, ctrl_b}, {3'b000, ec_b});
    check("disp_r1", disp_b, ed_b);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
`ifdef SS_DISPLAY_HEX_EN
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
`else
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111111;
`endif

    // Reset held three cycles with arbitrary input
    step(1'b1, 16'h1234);
    step(1'b1, 16'h8888);
    step(1'b1, 16'h3210);
    check("reset_ctrl_lit", {3'b000, ctrl_a}, 7'b0001111);
    check("reset_disp_lit", disp_a, 7'b1111111);

    // Scan of 3210 over two full frames
    step(1'b0, 16'h3210);
    check("release_ctrl_lit", {3'b000, ctrl_a}, 7'b0001110);
    check("release_disp_lit", disp_a, 7'b1000000);
    for (int i = 1; i < 32; i++) step(1'b0, 16'h3210);

    // Full-range digits, value switched inside digit 0's slot
    step(1'b1, 16'h9876);
    for (int i = 0; i < 2; i++) step(1'b0, 16'h9876);
    for (int i = 0; i < 14; i++) step(1'b0, 16'h5454);
    step(1'b1, 16'h9876);
    for (int i = 0; i < 14; i++) step(1'b0, 16'h9876);
    check("d3_nine_lit", disp_a, 7'b0010000);
    step(1'b0, 16'h5454);
    check("d3_five_lit", disp_a, 7'b0010010);
    step(1'b0, 16'h5454);

    // Non-BCD nibbles on digits 2 and 3
    step(1'b1, 16'hFA00);
    for (int i = 0; i < 16; i++) step(1'b0, 16'hFA00);

    // Reset in the middle of digit 2, then a full-length digit 0 slot
    step(1'b1, 16'h4321);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h4321);
    step(1'b1, 16'h4321);
    check("midreset_blank_lit", disp_a, 7'b1111111);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h4321);

    // Randomized input with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
